// File: rtl/paddle_input_hub_pkg.sv
// paddle_input_hub_pkg: shared types and defaults for the paddle input hub.
package paddle_input_hub_pkg;
    localparam int PADDLE_DEFAULT_VALUE_W = 8;
    typedef enum logic [1:0] {IDLE, DRAIN, CHARGE, UPDATE} paddle_hub_state_e;
endpackage

// File: rtl/paddle_input_hub_if.sv
// paddle_input_hub_if: paddle pads, buttons and filtered-value bus of the paddle input hub.
interface paddle_input_hub_if #(
    parameter int NUM_CH  = 2,
    parameter int VALUE_W = 8
);
    logic                        sample_start;
    logic [NUM_CH-1:0]           measure;
    logic [NUM_CH-1:0]           drain_capacitance;
    logic [NUM_CH-1:0]           button_raw;
    logic [NUM_CH*VALUE_W-1:0]   value;
    logic                        value_valid;
    logic [NUM_CH-1:0]           button;
    logic                        busy;
    modport master (
        output sample_start, measure, button_raw,
        input  drain_capacitance, value, value_valid, button, busy
    );
    modport slave (
        input  sample_start, measure, button_raw,
        output drain_capacitance, value, value_valid, button, busy
    );
endinterface

// File: rtl/paddle_input_hub_channel.sv
// paddle_input_hub_channel: one paddle lane - measure sync, count latch, moving-window filter, button debounce.
// With PADDLE_HUB_CALIB_EN the lane subtracts the lowest filtered value seen so far.
module paddle_input_hub_channel
    import paddle_input_hub_pkg::*;
#(
    parameter int VALUE_W         = PADDLE_DEFAULT_VALUE_W,
    parameter int AVG_DEPTH_LOG2  = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               measure_i,
    input  logic               button_raw_i,
    input  logic               clr_i,
    input  logic               charge_i,
    input  logic               update_i,
    input  logic [VALUE_W-1:0] count_i,
    output logic               done_o,
    output logic               button_o,
    output logic [VALUE_W-1:0] value_o
);
    localparam int DEPTH = 2 ** AVG_DEPTH_LOG2;
    localparam int SUM_W = VALUE_W + AVG_DEPTH_LOG2;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]                meas_sync_q, btn_sync_q;
    logic [VALUE_W-1:0]        raw_q, filt_q, filt_d;
    logic [VALUE_W-1:0]        ring_q [DEPTH];
    logic [AVG_DEPTH_LOG2-1:0] wp_q;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic [DB_W-1:0]           db_q;
    logic                      done_q, btn_q, db_hit;

    assign sum_d    = sum_q - SUM_W'(ring_q[wp_q]) + SUM_W'(raw_q);
    assign filt_d   = sum_d[SUM_W-1 -: VALUE_W];
    assign db_hit   = (btn_sync_q[1] != btn_q) && (db_q == DB_W'(DEBOUNCE_CYCLES - 1));
    assign done_o   = done_q;
    assign button_o = btn_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meas_sync_q <= '0;
            btn_sync_q  <= '0;
            raw_q       <= '0;
            done_q      <= 1'b0;
            filt_q      <= '0;
            sum_q       <= '0;
            wp_q        <= '0;
            db_q        <= '0;
            btn_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
        end else begin
            meas_sync_q <= {meas_sync_q[0], measure_i};
            btn_sync_q  <= {btn_sync_q[0], button_raw_i};
            // a lane that never sees its comparator trip takes the saturated count
            if (clr_i) begin
                raw_q  <= '0;
                done_q <= 1'b0;
            end else if (charge_i && !done_q && (meas_sync_q[1] || &count_i)) begin
                raw_q  <= count_i;
                done_q <= 1'b1;
            end
            if (update_i) begin
                ring_q[wp_q] <= raw_q;
                wp_q         <= wp_q + 1'b1;
                sum_q        <= sum_d;
                filt_q       <= filt_d;
            end
            db_q <= (btn_sync_q[1] == btn_q || db_hit) ? '0 : db_q + 1'b1;
            if (db_hit) btn_q <= btn_sync_q[1];
        end
    end

`ifdef PADDLE_HUB_CALIB_EN
    logic [VALUE_W-1:0] min_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) min_q <= '1;
        else if (update_i && filt_d < min_q) min_q <= filt_d;
    end
    assign value_o = (filt_q >= min_q) ? filt_q - min_q : '0;
`else
    assign value_o = filt_q;
`endif
endmodule

// File: rtl/paddle_input_hub.sv
// paddle_input_hub: per-frame conversion sequencer shared by NUM_CH paddle lanes.
// Define PADDLE_HUB_CALIB_EN to enable per-lane minimum offset cancellation.
module paddle_input_hub
    import paddle_input_hub_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int VALUE_W         = PADDLE_DEFAULT_VALUE_W,
    parameter int AVG_DEPTH_LOG2  = 2,
    parameter int DRAIN_CYCLES    = 64,
    parameter int PRESCALE        = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input logic               clk,
    input logic               reset_n,
    paddle_input_hub_if.slave bus
);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    paddle_hub_state_e         state_q, state_d;
    logic [DRAIN_W-1:0]        drain_cnt_q;
    logic [PRE_W-1:0]          pre_q;
    logic [VALUE_W-1:0]        count_q;
    logic                      valid_q, charge, update, clr, drain, busy, tick;
    logic [NUM_CH-1:0]         done, button;
    logic [NUM_CH*VALUE_W-1:0] value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.sample_start) state_d = DRAIN;
            DRAIN:   if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = CHARGE;
            CHARGE:  if (&done) state_d = UPDATE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        charge = state_q == CHARGE;
        update = state_q == UPDATE;
        clr    = state_q == DRAIN && state_d == CHARGE;
        drain  = !(charge || update);
        busy   = state_q != IDLE;
        tick   = pre_q == PRE_W'(PRESCALE - 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_cnt_q <= '0;
            pre_q       <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;
            valid_q     <= update;
            if (clr) begin
                pre_q   <= '0;
                count_q <= '0;
            end else if (charge) begin
                pre_q <= tick ? '0 : pre_q + 1'b1;
                if (tick && !(&count_q)) count_q <= count_q + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        paddle_input_hub_channel #(
            .VALUE_W        (VALUE_W),
            .AVG_DEPTH_LOG2 (AVG_DEPTH_LOG2),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .measure_i   (bus.measure[c]),
            .button_raw_i(bus.button_raw[c]),
            .clr_i       (clr),
            .charge_i    (charge),
            .update_i    (update),
            .count_i     (count_q),
            .done_o      (done[c]),
            .button_o    (button[c]),
            .value_o     (value[c*VALUE_W +: VALUE_W])
        );
    end

    assign bus.drain_capacitance = {NUM_CH{drain}};
    assign bus.value             = value;
    assign bus.value_valid       = valid_q;
    assign bus.button            = button;
    assign bus.busy              = busy;
endmodule
